vga_pixel_prefetch: RTL and testbench

Framebuffer-read stage directly upstream of `vga_generator`. Streams the 300x300 8-bit grayscale image out of framebuffer memory in raster order through a request/grant read port with variable latency. Buffers pixels in a small FIFO and hands one pixel per pop to the generator's `color` input. Restarts at address 0 on every frame-start pulse, so a late or lost pixel never shifts the image across frames.

---
 rtl/vga_pixel_prefetch.sv | 164 ++++++++++++++++
 tb/tb_vga_pixel_prefetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_prefetch.sv
// Framebuffer prefetch stage for vga_generator: raster-order reads over a req/gnt
// port into a small pixel FIFO, restarting from pixel 0 on every frame_start.
module vga_pixel_prefetch #(
  parameter int unsigned IMG_PIXELS = 90000,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        frame_start,
  input  logic                        pixel_pop,
  output logic [7:0]                  color,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_gnt,
  input  logic                        mem_rvalid,
  input  logic [7:0]                  mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned SUM_W = LVL_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] issued, issued_nxt;
  logic [LVL_W-1:0]  outstanding, outstanding_nxt;
  logic [LVL_W-1:0]  drop_cnt, drop_cnt_nxt;
  logic [LVL_W-1:0]  level_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
  logic [7:0]        color_nxt;
  logic              underflow_nxt;
  logic              mem_req_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [SUM_W-1:0]  stale;
  logic [SUM_W-1:0]  credit_sum;

  logic [7:0] fifo_mem [FIFO_DEPTH];

  logic gnt_acc;
  logic fifo_empty;
  logic resp_keep;
  logic resp_drop;
  logic fifo_push;
  logic pop_hit;

  assign gnt_acc    = mem_req & mem_gnt;
  assign fifo_empty = (fifo_level == '0);
  assign resp_keep  = mem_rvalid & (drop_cnt == '0);
  assign resp_drop  = mem_rvalid & (drop_cnt != '0);
  assign fifo_push  = resp_keep & ~frame_start;
  assign pop_hit    = pixel_pop & ~fifo_empty;

  // Next-state, FIFO bookkeeping and registered-output computation
  always_comb begin
    state_nxt       = state;
    issued_nxt      = issued;
    outstanding_nxt = outstanding;
    drop_cnt_nxt    = drop_cnt;
    level_nxt       = fifo_level;
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;
    color_nxt       = color;
    underflow_nxt   = underflow;
    stale           = '0;

    if (frame_start) begin
      // Everything still in flight from the old frame must be discarded on return
      stale = SUM_W'(drop_cnt) + SUM_W'(outstanding) + SUM_W'(gnt_acc)
              - SUM_W'(mem_rvalid);
      state_nxt       = ST_FETCH;
      issued_nxt      = '0;
      outstanding_nxt = '0;
      drop_cnt_nxt    = LVL_W'(stale);
      level_nxt       = '0;
      wr_ptr_nxt      = '0;
      rd_ptr_nxt      = '0;
      underflow_nxt   = 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (gnt_acc && (issued == ADDR_W'(IMG_PIXELS - 1))) begin
            state_nxt = ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: state_nxt = state;
        default:          state_nxt = ST_IDLE;
      endcase

      if (gnt_acc) begin
        issued_nxt = issued + ADDR_W'(1);
      end
      if (resp_drop) begin
        drop_cnt_nxt = drop_cnt - LVL_W'(1);
      end
      outstanding_nxt = outstanding + LVL_W'(gnt_acc) - LVL_W'(resp_keep);

      if (resp_keep) begin
        wr_ptr_nxt = wr_ptr + PTR_W'(1);
      end
      if (pop_hit) begin
        color_nxt  = fifo_mem[rd_ptr];
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end else if (pixel_pop) begin
        color_nxt     = 8'd0;
        underflow_nxt = 1'b1;
      end
      level_nxt = fifo_level + LVL_W'(resp_keep) - LVL_W'(pop_hit);
    end

    // Credit: every granted read is guaranteed a FIFO slot when it returns
    credit_sum  = SUM_W'(level_nxt) + SUM_W'(outstanding_nxt);
    mem_req_nxt = 1'b0;
    if (state_nxt == ST_FETCH) begin
      mem_req_nxt = (mem_req & ~mem_gnt & ~frame_start)
                  | (credit_sum < SUM_W'(FIFO_DEPTH));
    end
    mem_addr_nxt = ADDR_W'(BASE_ADDR) + issued_nxt;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      issued      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_level  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      color       <= 8'd0;
      underflow   <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= ADDR_W'(BASE_ADDR);
    end else begin
      state       <= state_nxt;
      issued      <= issued_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      fifo_level  <= level_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      color       <= color_nxt;
      underflow   <= underflow_nxt;
      mem_req     <= mem_req_nxt;
      mem_addr    <= mem_addr_nxt;
    end
  end

  // Pixel storage; contents need no reset since level/pointers gate every read
  always_ff @(posedge clk) begin
    if (reset_n && fifo_push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Randomized self-checking bench: a frame-epoch based model of the prefetcher
// plus a latency-queue memory, compared against the DUT every cycle.
module tb_vga_pixel_prefetch;

  localparam int unsigned IMG   = 1000;
  localparam int unsigned AW    = 18;
  localparam int unsigned BASE  = 0;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DONE  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_start;
  logic          pixel_pop;
  logic [7:0]    color;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [7:0]    mem_rdata;
  logic [LW-1:0] fifo_level;
  logic          underflow;

  always #5 clk = ~clk;

  vga_pixel_prefetch #(
    .IMG_PIXELS(IMG),
    .ADDR_W    (AW),
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .pixel_pop  (pixel_pop),
    .color      (color),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fifo_level (fifo_level),
    .underflow  (underflow)
  );

  typedef struct {
    int unsigned addr;
    int          epoch;
    int          due;
  } rsp_t;

  rsp_t       mq[$];
  logic [7:0] mfifo[$];
  int         epoch;
  int         m_issued;
  int         m_state;
  logic [7:0] m_color;
  bit         m_uf;
  bit         m_req;
  int         cyc;
  int         last_due;
  int         gnt_pct;
  int         lat_min;
  int         lat_max;
  int         total;
  int         bad;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int inflight_now();
    int n = 0;
    foreach (mq[i]) if (mq[i].epoch == epoch) n++;
    return n;
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare outputs
  task automatic step(input bit fs, input bit pop, input bit rst = 1'b0);
    bit          gnt;
    bit          rv;
    bit          granted;
    bit          hold;
    rsp_t        r;
    rsp_t        n;
    int unsigned g_addr;
    int          g_epoch;
    int          due;

    gnt = ($urandom_range(99) < gnt_pct);
    rv  = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
    reset_n     = !rst;
    frame_start = fs;
    pixel_pop   = pop;
    mem_gnt     = gnt;
    mem_rvalid  = rv;
    mem_rdata   = rv ? 8'(mq[0].addr) : 8'($urandom);

    @(posedge clk);
    if (rst) begin
      mq.delete();
      mfifo.delete();
      epoch++;
      m_issued = 0;
      m_state  = M_IDLE;
      m_color  = 8'd0;
      m_uf     = 1'b0;
      m_req    = 1'b0;
    end else begin
      granted = m_req && gnt;
      hold    = m_req && !gnt && !fs;
      g_addr  = BASE + m_issued;
      g_epoch = epoch;
      if (rv) r = mq.pop_front();
      if (fs) begin
        mfifo.delete();
        epoch++;
        m_issued = 0;
        m_uf     = 1'b0;
        m_state  = M_FETCH;
      end else begin
        if (pop) begin
          if (mfifo.size() > 0) m_color = mfifo.pop_front();
          else begin
            m_color = 8'd0;
            m_uf    = 1'b1;
          end
        end
        if (rv && r.epoch == epoch) mfifo.push_back(8'(r.addr));
        if (granted) begin
          m_issued++;
          if (m_issued == IMG) m_state = M_DONE;
        end
      end
      if (granted) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        n.addr  = g_addr;
        n.epoch = g_epoch;
        n.due   = due;
        mq.push_back(n);
      end
      m_req = (m_state == M_FETCH) &&
              (hold || (mfifo.size() + inflight_now() < DEPTH));
    end
    cyc++;
    #1;
    chk("color", int'(color), int'(m_color));
    chk("underflow", int'(underflow), int'(m_uf));
    chk("fifo_level", int'(fifo_level), mfifo.size());
    chk("mem_req", int'(mem_req), int'(m_req));
    if (m_req) chk("mem_addr", int'(mem_addr), int'((BASE + m_issued) % (1 << AW)));
  endtask

  initial begin
    int unsigned last_addr;
    bit          seen_last;
    bit          finished;

    total = 0; bad = 0; cyc = 0; last_due = -1; epoch = 0;
    m_issued = 0; m_state = M_IDLE; m_color = 8'd0; m_uf = 1'b0; m_req = 1'b0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    reset_n = 1'b0; frame_start = 1'b0; pixel_pop = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'd0;

    // Reset held with frame_start asserted, then a quiet period
    repeat (3) step(1'b1, 1'b0, 1'b1);
    chk("rst_color", int'(color), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_req", int'(mem_req), 0);
    chk("rst_underflow", int'(underflow), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      chk("idle_req", int'(mem_req), 0);
    end

    // Fill with zero-wait grant and 1-cycle latency, then drain 16 pixels
    step(1'b1, 1'b0);
    chk("first_req", int'(mem_req), 1);
    chk("first_addr", int'(mem_addr), int'(BASE));
    repeat (17) step(1'b0, 1'b0);
    chk("fill_level", int'(fifo_level), 16);
    chk("fill_req", int'(mem_req), 0);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1);
      chk("fill_color", int'(color), k);
    end
    chk("fill_underflow", int'(underflow), 0);

    // Random grant, variable latency, 30% pops, occasional restarts
    gnt_pct = 60; lat_min = 1; lat_max = 7;
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(999) == 0, $urandom_range(99) < 30);
    end

    // Underflow set by a pop on an empty FIFO, sticky until frame_start
    gnt_pct = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("uf_color", int'(color), 0);
    chk("uf_flag", int'(underflow), 1);
    repeat (3) step(1'b0, 1'b0);
    chk("uf_sticky", int'(underflow), 1);
    step(1'b1, 1'b0);
    chk("uf_cleared", int'(underflow), 0);

    // Mid-frame restart while five long-latency reads are in flight
    repeat (20) step(1'b0, 1'b0);
    gnt_pct = 100; lat_min = 7; lat_max = 7;
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    chk("restart_inflight", inflight_now(), 5);
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b0);
    chk("restart_addr", int'(mem_addr), int'(BASE));
    repeat (30) step(1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1);
      chk("restart_color", int'(color), k);
    end

    // Full frame popped at full rate
    seen_last = 1'b0; finished = 1'b0; last_addr = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < IMG + 200 && !finished; i++) begin
      if (m_req && m_issued == IMG - 1) begin
        last_addr = int'(mem_addr);
        seen_last = 1'b1;
      end
      step(1'b0, mfifo.size() > 0);
      finished = (m_state == M_DONE) && (mfifo.size() == 0) && (mq.size() == 0);
    end
    chk("frame_finished", int'(finished), 1);
    chk("frame_seen_last", int'(seen_last), 1);
    chk("frame_last_addr", int'(last_addr), int'(IMG - 1));
    repeat (3) step(1'b0, 1'b0);
    chk("frame_done_req", int'(mem_req), 0);
    chk("frame_done_uf", int'(underflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
